mic_level_meter: RTL and testbench

//  Upstream stage of the OLED volume-bar renderers. Takes 12-bit microphone samples and

---
 rtl/sound_pkg.sv | 24 ++
 rtl/therm_encoder.sv | 13 +
 rtl/mic_level_meter.sv | 102 ++++++++++
 tb/tb_mic_level_meter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound-level pipeline.
//   MIC_MID        : midscale of the 12-bit unsigned microphone sample (silence)
//   LEVEL_MAX      : highest displayable bar level
//   level_t        : 5-bit level, 0..16
//   therm_t        : 16-bit thermometer code, bit i set iff level > i
//   level_to_therm : level -> thermometer code; levels above 16 give all ones
package sound_pkg;

  localparam logic [11:0] MIC_MID   = 12'd2048;
  localparam logic [4:0]  LEVEL_MAX = 5'd16;

  typedef logic [4:0]  level_t;
  typedef logic [15:0] therm_t;

  function automatic therm_t level_to_therm(input level_t lvl);
    therm_t t;
    t = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (32'(lvl) > i) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/therm_encoder.sv
// Combinational level-to-thermometer encoder.
//   i_level : 5-bit binary level; values above 16 clamp to all ones
//   o_therm : 16-bit thermometer code (2^n-1 for n = 0..16)
module therm_encoder
  import sound_pkg::*;
(
  input  logic [4:0]  i_level,
  output logic [15:0] o_therm
);

  assign o_therm = level_to_therm(i_level);

endmodule

// File: rtl/mic_level_meter.sv
// Microphone peak level meter feeding the OLED volume-bar renderers.
// Tracks the peak deviation from midscale over WINDOW accepted samples and, at
// each window end, quantises it to a 0..16 level with limited per-window decay.
//   clock        : system clock, rising edge
//   resetn       : asynchronous active-low reset
//   mic_in       : 12-bit unsigned sample, 2048 = silence
//   sample_valid : sample strobe
//   freeze       : hold all state, drop samples
//   level_therm  : registered thermometer code of the displayed level
//   level_num    : registered displayed level, 0..16
//   update       : one-cycle pulse when the displayed level is rewritten
module mic_level_meter
  import sound_pkg::*;
#(
  parameter int unsigned WINDOW      = 4000,
  parameter int unsigned LEVEL_SHIFT = 7,
  parameter int unsigned DECAY_STEP  = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [11:0] mic_in,
  input  logic        sample_valid,
  input  logic        freeze,
  output logic [15:0] level_therm,
  output logic [4:0]  level_num,
  output logic        update
);

  localparam int unsigned      CW    = $clog2(WINDOW);
  localparam logic [CW-1:0]    LAST  = CW'(WINDOW - 1);
  localparam level_t           DECAY = level_t'(DECAY_STEP);

  logic [11:0]   r_peak;
  logic [CW-1:0] r_count;
  level_t        r_level;
  therm_t        r_therm;
  logic          r_update;

  logic          w_accept;
  logic          w_last;
  logic [11:0]   w_mag;
  logic [11:0]   w_peak_max;
  logic [11:0]   w_shifted;
  level_t        w_new;
  level_t        w_decayed;
  level_t        w_level_next;
  therm_t        w_therm_next;

  assign w_accept = sample_valid & ~freeze;
  assign w_last   = w_accept && (r_count == LAST);

  // 2048 - 0 = 2048 still fits in 12 bits, so no overflow on the low side.
  assign w_mag      = (mic_in >= MIC_MID) ? (mic_in - MIC_MID) : (MIC_MID - mic_in);
  assign w_peak_max = (w_mag > r_peak) ? w_mag : r_peak;
  assign w_shifted  = w_peak_max >> LEVEL_SHIFT;

  always_comb begin
    w_new        = (w_shifted > 12'(LEVEL_MAX)) ? LEVEL_MAX : w_shifted[4:0];
    w_decayed    = (r_level > DECAY) ? (r_level - DECAY) : '0;
    w_level_next = r_level;
    if (w_new >= r_level) begin
      w_level_next = w_new;
    end else begin
      w_level_next = (w_new > w_decayed) ? w_new : w_decayed;
    end
  end

  therm_encoder u_therm_encoder (
    .i_level (w_level_next),
    .o_therm (w_therm_next)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_peak   <= '0;
      r_count  <= '0;
      r_level  <= '0;
      r_therm  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          // The closing sample is folded into the level but never into the next window.
          r_peak   <= '0;
          r_count  <= '0;
          r_level  <= w_level_next;
          r_therm  <= w_therm_next;
          r_update <= 1'b1;
        end else begin
          r_peak  <= w_peak_max;
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign level_therm = r_therm;
  assign level_num   = r_level;
  assign update      = r_update;

endmodule

// File: tb/tb_mic_level_meter.sv
module tb_mic_level_meter;

  localparam int unsigned WINDOW = 4;

  logic        clock;
  logic        resetn;
  logic [11:0] mic_in;
  logic        sample_valid;
  logic        freeze;
  logic [15:0] level_therm;
  logic [4:0]  level_num;
  logic        update;

  mic_level_meter #(
    .WINDOW      (WINDOW),
    .LEVEL_SHIFT (7),
    .DECAY_STEP  (1)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .mic_in       (mic_in),
    .sample_valid (sample_valid),
    .freeze       (freeze),
    .level_therm  (level_therm),
    .level_num    (level_num),
    .update       (update)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned lvl;
    logic [15:0] therm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   upd_seen = 0;

  // reference model state
  int unsigned m_peak  = 0;
  int unsigned m_count = 0;
  int unsigned m_held  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [11:0] m);
    int unsigned mag, pk, nw, dec;
    exp_t e;
    mag = (m >= 12'd2048) ? int'(m) - 2048 : 2048 - int'(m);
    pk  = (mag > m_peak) ? mag : m_peak;
    if (m_count == WINDOW - 1) begin
      nw = pk / 128;
      if (nw > 16) nw = 16;
      if (nw >= m_held) m_held = nw;
      else begin
        dec    = (m_held > 1) ? m_held - 1 : 0;
        m_held = (nw > dec) ? nw : dec;
      end
      e.lvl   = m_held;
      e.therm = 16'((17'd1 << m_held) - 17'd1);
      q.push_back(e);
      m_peak  = 0;
      m_count = 0;
    end else begin
      m_peak  = pk;
      m_count = m_count + 1;
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [11:0] m, input logic f);
    @(posedge clock); #1;
    sample_valid = v;
    mic_in       = m;
    freeze       = f;
    if (v && !f) model_accept(m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 12'd2048, 1'b0);
  endtask

  task automatic window4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
    drive_cycle(1'b1, a, 1'b0);
    drive_cycle(1'b1, b, 1'b0);
    drive_cycle(1'b1, c, 1'b0);
    drive_cycle(1'b1, d, 1'b0);
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    sample_valid = 1'b0;
    resetn       = 1'b0;
    m_peak = 0; m_count = 0; m_held = 0;
    @(posedge clock); #2;
    check("rst_level_num", 32'(level_num), 32'd0);
    check("rst_therm", 32'(level_therm), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    resetn = 1'b1;
  endtask

  task automatic expect_out(input string tag, input int unsigned lvl, input logic [15:0] th);
    check({tag, "_lvl"}, 32'(level_num), lvl);
    check({tag, "_therm"}, 32'(level_therm), 32'(th));
  endtask

  // scoreboard side: compare on every update pulse, away from the active edge
  always @(negedge clock) begin
    if (resetn === 1'b1 && update === 1'b1) begin
      upd_seen++;
      check("upd_during_freeze", 32'(freeze), 32'd0);
      if (q.size() == 0) begin
        check("spurious_update", 32'(update), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_level_num", 32'(level_num), e.lvl);
        check("sb_therm", 32'(level_therm), 32'(e.therm));
        check("therm_legal", 32'(level_therm & (level_therm + 16'd1)), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    resetn       = 1'b0;
    sample_valid = 1'b0;
    mic_in       = 12'd2048;
    freeze       = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("init_level_num", 32'(level_num), 32'd0);
    check("init_therm", 32'(level_therm), 32'd0);
    check("init_update", 32'(update), 32'd0);
    resetn = 1'b1;

    // reset in the middle of a window discards the partial window
    drive_cycle(1'b1, 12'd4095, 1'b0);
    drive_cycle(1'b1, 12'd4095, 1'b0);
    do_reset();
    base = upd_seen;
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    expect_out("post_reset", 0, 16'h0000);
    check("post_reset_updates", 32'(upd_seen - base), 32'd1);

    // loud window, then decay through three silent windows
    window4(12'd2048, 12'd2048, 12'd0, 12'd2048);
    expect_out("loud", 16, 16'hFFFF);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    expect_out("decay1", 15, 16'h7FFF);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    expect_out("decay2", 14, 16'h3FFF);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    expect_out("decay3", 13, 16'h1FFF);

    // quantisation edges
    do_reset();
    window4(12'd2175, 12'd2048, 12'd2048, 12'd2048);
    expect_out("mag127", 0, 16'h0000);
    window4(12'd2048, 12'd2176, 12'd2048, 12'd2048);
    expect_out("mag128", 1, 16'h0001);
    window4(12'd2048, 12'd2048, 12'd1025, 12'd2048);
    expect_out("mag1023", 7, 16'h007F);

    // back-to-back strobes with a 3-cycle freeze: frozen loud samples are dropped
    base = upd_seen;
    drive_cycle(1'b1, 12'd2304, 1'b0);
    drive_cycle(1'b1, 12'd2304, 1'b0);
    drive_cycle(1'b1, 12'd4095, 1'b1);
    drive_cycle(1'b1, 12'd4095, 1'b1);
    drive_cycle(1'b1, 12'd4095, 1'b1);
    drive_cycle(1'b1, 12'd2048, 1'b0);
    check("freeze_no_close_early", 32'(upd_seen - base), 32'd0);
    drive_cycle(1'b1, 12'd2048, 1'b0);
    idle(2);
    expect_out("freeze", 6, 16'h003F);
    check("freeze_updates", 32'(upd_seen - base), 32'd1);

    // peak in the final sample of a window, and no carry into the next window
    do_reset();
    window4(12'd2048, 12'd2048, 12'd2048, 12'd3072);
    expect_out("last_peak", 8, 16'h00FF);
    window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
    expect_out("no_carry", 7, 16'h007F);

    idle(4);
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
